// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op codes, FSM states and widths for the HI/LO unit.
package hilo_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6
  } op_e;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_e;
endpackage

// File: rtl/hilo_fix.sv
// hilo_fix: undoes the multiplier's sign flip on unsigned products with mismatched top bits.
module hilo_fix (
  input  logic [63:0] mul_s,
  input  logic        is_signed,
  input  logic        a_sign,
  input  logic        b_sign,
  output logic [63:0] res
);
  assign res = (!is_signed && (a_sign ^ b_sign)) ? -mul_s : mul_s;
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO registers sequencing an iterative multiplier; HILO_BYPASS_EN forwards the product to MFHI/MFLO.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs_data,
  input  logic [31:0]     rt_data,
  output logic            stall,
  output logic [31:0]     rd_data,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  output logic            mul_start,
  output logic            mul_is_signed,
  output logic            mul_reset,
  input  logic [63:0]     mul_s,
  input  logic            mul_ready
);
  state_e      state, state_n;
  logic [63:0] res;
  logic        known, is_mf, capture, bypass, accept, launch;
  hilo_fix u_fix (
    .mul_s    (mul_s),
    .is_signed(mul_is_signed),
    .a_sign   (mul_a[31]),
    .b_sign   (mul_b[31]),
    .res      (res)
  );
  assign mul_reset = !reset;
  always_comb begin
    known   = op inside {[OP_MULT:OP_MFLO]};
    is_mf   = op == OP_MFHI || op == OP_MFLO;
    capture = state == BUSY && mul_ready;
`ifdef HILO_BYPASS_EN
    bypass  = capture && is_mf;
`else
    bypass  = 1'b0;
`endif
    stall   = op_valid && known && state != IDLE && !bypass;
    accept  = op_valid && !stall;
    launch  = state == IDLE && accept && (op == OP_MULT || op == OP_MULTU);
    rd_data = !(accept && is_mf) ? '0 :
              bypass ? (op == OP_MFHI ? res[63:32] : res[31:0]) :
              (op == OP_MFHI ? hi : lo);
    state_n = state == IDLE   ? (launch ? LAUNCH : IDLE) :
              state == LAUNCH ? BUSY :
              (state == BUSY && !mul_ready) ? BUSY : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      hi            <= '0;
      lo            <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_start     <= 1'b0;
      mul_is_signed <= 1'b0;
    end else begin
      state     <= state_n;
      mul_start <= launch;
      // operands stay put until capture: the multiplier reads their sign bits at completion
      if (launch) begin
        mul_a         <= rs_data;
        mul_b         <= rt_data;
        mul_is_signed <= op == OP_MULT;
      end
      if (capture) {hi, lo} <= res;
      if (accept && op == OP_MTHI) hi <= rs_data;
      if (accept && op == OP_MTLO) lo <= rs_data;
    end
  end
endmodule
